// File: rtl/mic1_shifter_if.sv
// mic1_shifter_if: ALU-operand and shifter-result bundle between the
// datapath driver and the MIC-1 shifter stage.
interface mic1_shifter_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] ALU_out;
    logic [1:0]       SET;
    logic             IN_VALID;
    logic [WIDTH-1:0] Shift;
    logic             OUT_VALID;
    logic             ILLEGAL;

    modport master (
        output ALU_out, SET, IN_VALID,
        input  Shift, OUT_VALID, ILLEGAL
    );

    modport slave (
        input  ALU_out, SET, IN_VALID,
        output Shift, OUT_VALID, ILLEGAL
    );
endinterface

// File: rtl/mic1_shifter.sv
// mic1_shifter: registered MIC-1 shifter stage.
// It performs pass, SLL, or SRA on the ALU result, with a valid strobe and an illegal-code flag.
module mic1_shifter #(
    parameter int WIDTH   = 32,
    parameter int SLL_AMT = 8,
    parameter int SRA_AMT = 1
) (
    input  logic          CLK,
    input  logic          RST,
    mic1_shifter_if.slave bus
);
    logic signed [WIDTH-1:0] w_sra;
    logic [WIDTH-1:0]        w_next;
    logic                    w_illegal;
    logic [WIDTH-1:0]        r_shift;
    logic                    r_valid;
    logic                    r_illegal;

    // SRA is computed in its own signed net so the surrounding unsigned mux cannot turn it logical
    assign w_sra = $signed(bus.ALU_out) >>> SRA_AMT;

    always_comb begin
        w_illegal = (bus.SET == 2'b11);
        w_next    = (bus.SET == 2'b00) ? bus.ALU_out :
                    (bus.SET == 2'b01) ? (bus.ALU_out << SLL_AMT) :
                    (bus.SET == 2'b10) ? w_sra : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shift   <= '0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (bus.IN_VALID) begin
            r_shift   <= w_next;
            r_valid   <= 1'b1;
            r_illegal <= w_illegal;
        end else begin
            r_valid   <= 1'b0;
        end
    end

    assign bus.Shift     = r_shift;
    assign bus.OUT_VALID = r_valid;
    assign bus.ILLEGAL   = r_illegal;
endmodule

// File: tb/tb_mic1_shifter.sv
// tb_mic1_shifter: directed and random checks of mic1_shifter against an arithmetic reference model.
module tb_mic1_shifter;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int total = 0;
    int bad = 0;
    logic [31:0] m_shift;
    logic        m_valid;
    logic        m_ill;

    mic1_shifter_if #(.WIDTH(32)) bus ();

    mic1_shifter #(.WIDTH(32), .SLL_AMT(8), .SRA_AMT(1)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'd0) return a;
        if (s == 2'd1) return a * 32'd256;
        if (s == 2'd2) return (a / 32'd2) + ((a >= 32'h8000_0000) ? 32'h8000_0000 : 32'd0);
        return 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".shift"}, bus.Shift, m_shift);
        chk({tag, ".valid"}, {31'd0, bus.OUT_VALID}, {31'd0, m_valid});
        chk({tag, ".ill"}, {31'd0, bus.ILLEGAL}, {31'd0, m_ill});
    endtask

    task automatic cyc(input logic [31:0] a, input logic [1:0] s, input logic v);
        bus.ALU_out  = a;
        bus.SET      = s;
        bus.IN_VALID = v;
        @(posedge CLK);
        if (v) begin
            m_shift = ref_op(a, s);
            m_valid = 1'b1;
            m_ill   = (s == 2'd3);
        end else begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic step(input string tag, input logic [31:0] a, input logic [1:0] s, input logic v);
        cyc(a, s, v);
        chk_all(tag);
    endtask

    initial begin
        bus.ALU_out  = 32'h0;
        bus.SET      = 2'd0;
        bus.IN_VALID = 1'b0;
        m_shift = 32'd0;
        m_valid = 1'b0;
        m_ill   = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk_all("reset");
        RST = 1'b0;
        step("pass", 32'hAAAA_AAAA, 2'd0, 1'b1);
        chk("pass.lit", bus.Shift, 32'hAAAA_AAAA);
        step("sll_a", 32'hAAAA_AAAA, 2'd1, 1'b1);
        chk("sll_a.lit", bus.Shift, 32'hAAAA_AA00);
        step("sll_b", 32'h1234_5678, 2'd1, 1'b1);
        chk("sll_b.lit", bus.Shift, 32'h3456_7800);
        step("sra_a", 32'hAAAA_AAAA, 2'd2, 1'b1);
        chk("sra_a.lit", bus.Shift, 32'hD555_5555);
        step("sra_b", 32'h5555_5554, 2'd2, 1'b1);
        chk("sra_b.lit", bus.Shift, 32'h2AAA_AAAA);
        step("sra_c", 32'h8000_0000, 2'd2, 1'b1);
        chk("sra_c.lit", bus.Shift, 32'hC000_0000);
        step("illegal", 32'hAAAA_AAAA, 2'd3, 1'b1);
        chk("illegal.lit", {31'd0, bus.ILLEGAL}, 32'd1);
        step("ill_clear", 32'h0000_0001, 2'd0, 1'b1);
        chk("ill_clear.lit", {31'd0, bus.ILLEGAL}, 32'd0);
        step("hold_load", 32'hFFFF_FFFF, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step("hold", 32'h0F0F_0F0F ^ {32{i[0]}}, 2'(i), 1'b0);
            chk("hold.lit", bus.Shift, 32'hFFFF_FFFF);
        end
        step("str0", 32'h8765_4321, 2'd0, 1'b1);
        step("str1", 32'h8765_4321, 2'd1, 1'b1);
        step("str2", 32'h8765_4321, 2'd2, 1'b1);
        step("str3", 32'h0000_00FF, 2'd0, 1'b1);
        step("pre_rst", 32'hAAAA_AAAA, 2'd2, 1'b1);
        bus.IN_VALID = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        m_shift = 32'd0;
        m_valid = 1'b0;
        m_ill   = 1'b0;
        chk_all("async_rst");
        @(negedge CLK);
        RST = 1'b0;
        step("post_rst", 32'h1234_5678, 2'd2, 1'b1);
        for (int i = 0; i < 300; i++) begin
            cyc($urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
            chk_all("rand");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
